// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: widths, opcode map and instruction field layout.
package alu_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 8;
  localparam int unsigned OPW    = 5;
  localparam int unsigned MAX_OP = 13;
  localparam int unsigned RAW    = 3;

  localparam logic [OPW-1:0] OP_ADD = 5'd0;
  localparam logic [OPW-1:0] OP_SUB = 5'd1;
  localparam logic [OPW-1:0] OP_AND = 5'd2;
  localparam logic [OPW-1:0] OP_OR  = 5'd3;

  localparam int unsigned OP_LSB  = 27;
  localparam int unsigned RD_LSB  = 24;
  localparam int unsigned RS1_LSB = 21;
  localparam int unsigned RS2_LSB = 18;
  localparam int unsigned IMM_BIT = 17;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } issue_state_t;
endpackage

// File: rtl/alu_regfile.sv
// Register file: two async read ports, one sync write port, R0 hardwired to zero, write-through bypass.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = alu_pkg::XLEN,
  parameter int unsigned NREG = alu_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(NREG)-1:0] raddr1,
  input  logic [$clog2(NREG)-1:0] raddr2,
  output logic [XLEN-1:0]         rdata1,
  output logic [XLEN-1:0]         rdata2,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [XLEN-1:0]         wdata
);
  logic [XLEN-1:0] mem [NREG];
  logic            wr_en;

  assign wr_en = we & (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (wr_en && waddr == raddr1) ? wdata : mem[raddr1];
    if (raddr2 != '0) rdata2 = (wr_en && waddr == raddr2) ? wdata : mem[raddr2];
  end
endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage ahead of the ALU: operand read, scoreboard hazard stall, registered ALU drive.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN   = alu_pkg::XLEN,
  parameter int unsigned NREG   = alu_pkg::NREG,
  parameter int unsigned OPW    = alu_pkg::OPW,
  parameter int unsigned MAX_OP = alu_pkg::MAX_OP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  input  logic            wb_valid,
  input  logic [2:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [OPW-1:0]  alu_opcode,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            alu_enable,
  output logic [2:0]      alu_rd,
  output logic            illegal_op
);
  logic [OPW-1:0]  op;
  logic [RAW-1:0]  rd, rs1, rs2;
  logic            use_imm;
  logic [15:0]     imm16;
  logic            unused_bit;
  logic [XLEN-1:0] rdata1, rdata2, b_val;
  logic [NREG-1:0] sb, sb_clr, sb_eff, sb_next;
  logic            hazard, accept, legal, issue, bad;
  issue_state_t    state, state_next;

  assign op         = instr[OP_LSB +: OPW];
  assign rd         = instr[RD_LSB +: RAW];
  assign rs1        = instr[RS1_LSB +: RAW];
  assign rs2        = instr[RS2_LSB +: RAW];
  assign use_imm    = instr[IMM_BIT];
  assign imm16      = instr[15:0];
  assign unused_bit = instr[16];

  alu_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (wb_valid),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  // A writeback landing this cycle already frees its register for the hazard check.
  assign sb_clr = wb_valid ? (NREG'(1) << wb_rd) : '0;
  assign sb_eff = sb & ~sb_clr;
  assign hazard = sb_eff[rs1] | (~use_imm & sb_eff[rs2]) | ((rd != '0) & sb_eff[rd]);
  assign legal  = (op <= OPW'(MAX_OP));
  assign accept = instr_valid & ~hazard;
  assign b_val  = use_imm ? {{(XLEN-16){imm16[15]}}, imm16} : rdata2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (instr_valid && hazard) state_next = ST_STALL;
      ST_STALL: if (accept || !instr_valid) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_comb begin
    instr_ready = ~hazard;
    issue       = accept & legal;
    bad         = accept & ~legal;
  end

  always_comb begin
    sb_next = sb & ~sb_clr;
    if (issue && rd != '0) sb_next[rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb         <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_rd     <= '0;
      alu_enable <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      sb         <= sb_next;
      alu_enable <= issue;
      illegal_op <= bad;
      if (issue) begin
        alu_opcode <= op;
        alu_a      <= rdata1;
        alu_b      <= b_val;
        alu_rd     <= rd;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a, alu_b;
  logic        alu_enable;
  logic [2:0]  alu_rd;
  logic        illegal_op;

  int passed = 0;
  int total  = 0;

  alu_issue_stage #(.XLEN(32), .NREG(8), .OPW(5), .MAX_OP(13)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_enable  (alu_enable),
    .alu_rd      (alu_rd),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic imm, input logic [15:0] imm16);
    return {op, rd, rs1, rs2, imm, 1'b0, imm16};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [2:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    instr_valid = 1'b1; instr = mk(OP_SUB, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234);

    // 1. reset holds everything at zero even with a valid instruction present
    tick(); tick();
    check("rst_enable", alu_enable, 0);
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    check("rst_op", alu_opcode, 0);
    check("rst_rd", alu_rd, 0);
    check("rst_illegal", illegal_op, 0);
    instr_valid = 1'b0; rst_n = 1'b1;
    #1 check("rst_ready", instr_ready, 1);
    tick();
    check("rst_no_pulse", alu_enable, 0);

    // 2. immediate issue with sign extension
    instr = mk(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF); instr_valid = 1'b1;
    #1 check("imm_ready", instr_ready, 1);
    tick(); instr_valid = 1'b0;
    check("imm_enable", alu_enable, 1);
    check("imm_a", alu_a, 32'h0);
    check("imm_b", alu_b, 32'hFFFFFFFF);
    check("imm_rd", alu_rd, 1);
    tick();
    check("imm_pulse_end", alu_enable, 0);
    check("imm_b_hold", alu_b, 32'hFFFFFFFF);
    wb(3'd1, 32'h11);

    // 3. RAW stall released by writeback with bypass
    instr = mk(OP_SUB, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0005); instr_valid = 1'b1;
    tick();
    instr = mk(OP_SUB, 3'd4, 3'd2, 3'd0, 1'b1, 16'h0000);
    #1 check("raw_stall", instr_ready, 0);
    tick();
    check("raw_stall_hold", instr_ready, 0);
    check("raw_no_issue", alu_enable, 0);
    wb_valid = 1'b1; wb_rd = 3'd2; wb_data = 32'h0F0F0F0F;
    #1 check("raw_release", instr_ready, 1);
    tick(); wb_valid = 1'b0; instr_valid = 1'b0;
    check("raw_enable", alu_enable, 1);
    check("raw_bypass_a", alu_a, 32'h0F0F0F0F);
    check("raw_rd", alu_rd, 4);
    wb(3'd4, 32'h44);

    // 4. WAW with same-cycle clear and set: set wins
    instr = mk(OP_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0000); instr_valid = 1'b1;
    tick();
    instr = mk(OP_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0001);
    wb_valid = 1'b1; wb_rd = 3'd3; wb_data = 32'h0;
    #1 check("waw_ready", instr_ready, 1);
    tick(); wb_valid = 1'b0; instr_valid = 1'b0;
    check("waw_enable", alu_enable, 1);
    check("waw_b", alu_b, 32'h1);
    instr = mk(OP_AND, 3'd5, 3'd3, 3'd2, 1'b0, 16'h0000);
    #1 check("waw_set_wins", instr_ready, 0);
    wb(3'd3, 32'h33);
    instr_valid = 1'b1;
    #1 check("waw_cleared", instr_ready, 1);
    tick(); instr_valid = 1'b0;
    check("reg_a", alu_a, 32'h33);
    check("reg_b", alu_b, 32'h0F0F0F0F);
    check("reg_op", alu_opcode, OP_AND);
    wb(3'd5, 32'h55);

    // 5. illegal opcode: pulse, no issue, scoreboard untouched
    instr = mk(5'b10000, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0000); instr_valid = 1'b1;
    #1 check("ill_ready", instr_ready, 1);
    tick(); instr_valid = 1'b0;
    check("ill_pulse", illegal_op, 1);
    check("ill_no_enable", alu_enable, 0);
    check("ill_rd_hold", alu_rd, 5);
    instr = mk(OP_ADD, 3'd1, 3'd6, 3'd6, 1'b0, 16'h0000);
    #1 check("ill_sb_clear", instr_ready, 1);
    tick();
    check("ill_pulse_end", illegal_op, 0);

    // 6. R0: never busy, reads zero, writeback ignored
    instr = mk(OP_OR, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0007); instr_valid = 1'b1;
    tick();
    check("r0_first", alu_enable, 1);
    instr = mk(OP_OR, 3'd7, 3'd0, 3'd0, 1'b0, 16'h0000);
    wb_valid = 1'b1; wb_rd = 3'd0; wb_data = 32'hDEADBEEF;
    #1 check("r0_no_stall", instr_ready, 1);
    tick(); wb_valid = 1'b0; instr_valid = 1'b0;
    check("r0_enable", alu_enable, 1);
    check("r0_a", alu_a, 0);
    check("r0_b", alu_b, 0);
    check("r0_rd", alu_rd, 7);

    // 7. reset mid-operation drops the pending accept and clears regfile/scoreboard
    instr = mk(OP_ADD, 3'd1, 3'd2, 3'd0, 1'b1, 16'h0000); instr_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("mid_rst_enable", alu_enable, 0);
    tick(); instr_valid = 1'b0; rst_n = 1'b1;
    tick();
    check("mid_rst_no_pulse", alu_enable, 0);
    instr = mk(OP_ADD, 3'd1, 3'd7, 3'd2, 1'b0, 16'h0000); instr_valid = 1'b1;
    #1 check("mid_rst_sb", instr_ready, 1);
    tick(); instr_valid = 1'b0;
    check("mid_rst_enable2", alu_enable, 1);
    check("mid_rst_regfile", alu_b, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
